// File: rtl/bexkat_write_buffer.sv
// bexkat_write_buffer: posted-write buffer between the bexkat2 CPU master and memory.
// CPU writes are queued in a small FIFO and drained to memory in order. A read waits
// until the FIFO is empty and then issues a single registered memory transaction, so
// memory always observes strict program order.
module bexkat_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DW-1:0]     cpu_writedata,
    input  logic [DW/8-1:0]   cpu_byteenable,
    output logic [DW-1:0]     cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [AW-1:0]     mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic [DW/8-1:0]   mem_byteenable,
    input  logic [DW-1:0]     mem_readdata,
    input  logic              mem_waitrequest,
    output logic              idle
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_DONE
    } state_t;

    state_t state, state_nx;

    // FIFO storage and bookkeeping
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [BW-1:0] fifo_be   [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;

    // Read transaction registers
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_be;
    logic [DW-1:0] rd_data;

    logic push, pop, start_rd, capture;

    // Full looks only at the registered count: a pop in the same cycle does not free a slot yet.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign idle         = empty && (state == IDLE);
    assign cpu_readdata = rd_data;

    // Entry storage: written on push only.
    // NOTE: the data array carries no reset; validity is tracked by the pointers and count,
    // so clearing the payload would add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_address;
            fifo_data[wr_ptr] <= cpu_writedata;
            fifo_be[wr_ptr]   <= cpu_byteenable;
        end
    end

    // FIFO pointers and occupancy; reset discards any pending writes.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Read FSM state and the registered read address/lanes/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_be   <= '0;
            rd_data <= '0;
        end else begin
            state <= state_nx;
            if (start_rd) begin
                rd_addr <= cpu_address;
                rd_be   <= cpu_byteenable;
            end
            if (capture) rd_data <= mem_readdata;
        end
    end

    // Next state, FIFO handshakes and both bus ports.
    // NOTE: every output of this block gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_nx        = state;
        push            = 1'b0;
        pop             = 1'b0;
        start_rd        = 1'b0;
        capture         = 1'b0;
        cpu_waitrequest = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_writedata   = '0;
        mem_byteenable  = '0;
        case (state)
            IDLE: begin
                // Drain the head entry whenever anything is queued.
                if (!empty) begin
                    mem_write      = 1'b1;
                    mem_address    = fifo_addr[rd_ptr];
                    mem_writedata  = fifo_data[rd_ptr];
                    mem_byteenable = fifo_be[rd_ptr];
                    pop            = !mem_waitrequest;
                end
                // A write wins over an (illegal) simultaneous read.
                if (cpu_write) begin
                    cpu_waitrequest = full;
                    push            = !full;
                end else if (cpu_read) begin
                    cpu_waitrequest = 1'b1;
                    if (empty) begin
                        start_rd = 1'b1;
                        state_nx = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_read        = 1'b1;
                mem_address     = rd_addr;
                mem_byteenable  = rd_be;
                cpu_waitrequest = cpu_read || cpu_write;
                if (!mem_waitrequest) begin
                    capture  = 1'b1;
                    state_nx = RD_DONE;
                end
            end
            RD_DONE: begin
                // One-cycle completion window; readdata comes straight from rd_data.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Simulation-only protocol checks.
    a_no_rw_together : assert property (@(posedge clk) disable iff (reset)
        !(cpu_read && cpu_write))
        else $error("bexkat_write_buffer: cpu_read and cpu_write asserted together");

    a_mem_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write))
        else $error("bexkat_write_buffer: mem_read and mem_write asserted together");

endmodule

// File: tb/tb_bexkat_write_buffer.sv
// Testbench for bexkat_write_buffer: randomized writes and reads checked against a
// queue-based model of the posted-write buffer and a simple associative memory.
module tb_bexkat_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;

    logic          clk;
    logic          reset;
    logic [AW-1:0] cpu_address;
    logic          cpu_read;
    logic          cpu_write;
    logic [DW-1:0] cpu_writedata;
    logic [BW-1:0] cpu_byteenable;
    logic [DW-1:0] cpu_readdata;
    logic          cpu_waitrequest;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic [BW-1:0] mem_byteenable;
    logic [DW-1:0] mem_readdata;
    logic          mem_waitrequest;
    logic          idle;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } op_t;

    op_t         log_q[$];   // memory-side transfers as observed
    op_t         exp_q[$];   // writes the model expects memory to receive
    logic [31:0] mem_model [logic [31:0]];

    bexkat_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_byteenable  (cpu_byteenable),
        .cpu_readdata    (cpu_readdata),
        .cpu_waitrequest (cpu_waitrequest),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .idle            (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: log every completed transfer and update the memory model.
    always @(posedge clk) begin
        op_t o;
        if (!reset && !mem_waitrequest && (mem_write || mem_read)) begin
            o.is_wr = mem_write;
            o.addr  = mem_address;
            o.data  = mem_writedata;
            o.be    = mem_byteenable;
            log_q.push_back(o);
            if (mem_write) mem_model[mem_address] = mem_writedata;
        end
    end

    // Memory read data, refreshed away from the sampling edge.
    always @(negedge clk)
        mem_readdata = mem_model.exists(mem_address) ? mem_model[mem_address] : 32'h0;

    // Issue one CPU write; returns once the transfer edge has passed.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                            output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cpu_address = a; cpu_writedata = d; cpu_byteenable = b; cpu_write = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!cpu_waitrequest) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) exp_q.push_back('{is_wr: 1'b1, addr: a, data: d, be: b});
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    // Issue one CPU read; lat counts cycles from request to completion.
    task automatic do_read(input logic [31:0] a, input logic [3:0] b, output bit ok,
                           output logic [31:0] d, output int lat);
        ok = 1'b0; d = '0; lat = 0;
        @(negedge clk);
        cpu_address = a; cpu_byteenable = b; cpu_read = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!cpu_waitrequest) begin ok = 1'b1; d = cpu_readdata; break; end
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        cpu_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (mem_read !== 1'b0)        begin bad++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
        total++; if (mem_write !== 1'b0)       begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        total++; if (idle !== 1'b1)            begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        total++; if (cpu_readdata !== 32'h0)   begin bad++; $display("FAIL reset_readdata got=%h exp=0", cpu_readdata); end
        total++; if (mem_address !== 32'h0)    begin bad++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
        total++; if (mem_writedata !== 32'h0)  begin bad++; $display("FAIL reset_mem_writedata got=%h exp=0", mem_writedata); end
        total++; if (mem_byteenable !== 4'h0)  begin bad++; $display("FAIL reset_mem_be got=%h exp=0", mem_byteenable); end
        total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_waitreq got=%b exp=0", cpu_waitrequest); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Five back-to-back writes against a stalled memory: four fit, the fifth waits for a pop.
    task automatic test_fill_full();
        logic [31:0] av [5];
        logic [31:0] dv [5];
        logic [3:0]  bv [5];
        bit          done;
        log_q.delete(); exp_q.delete();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            av[i] = 32'h200 + 32'(4 * i);
            dv[i] = $urandom;
            bv[i] = 4'($urandom_range(1, 15));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_address = av[i]; cpu_writedata = dv[i]; cpu_byteenable = bv[i]; cpu_write = 1'b1;
            #1;
            total++;
            if (cpu_waitrequest !== (i == 4)) begin
                bad++; $display("FAIL fill_accept[%0d] waitreq got=%b exp=%b", i, cpu_waitrequest, (i == 4));
            end
            if (!cpu_waitrequest) exp_q.push_back('{is_wr: 1'b1, addr: av[i], data: dv[i], be: bv[i]});
        end
        total++; if (mem_write !== 1'b1 || mem_address !== av[0]) begin
            bad++; $display("FAIL fill_head got=%b/%h exp=1/%h", mem_write, mem_address, av[0]);
        end
        @(negedge clk); #1;
        total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL full_hold got=%b exp=1", cpu_waitrequest); end
        mem_waitrequest = 1'b0;
        #1;
        total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL full_no_bypass got=%b exp=1", cpu_waitrequest); end
        @(negedge clk); #1;
        total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL full_freed got=%b exp=0", cpu_waitrequest); end
        if (!cpu_waitrequest) exp_q.push_back('{is_wr: 1'b1, addr: av[4], data: dv[4], be: bv[4]});
        @(negedge clk);
        cpu_write = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (idle) begin done = 1'b1; break; end
        end
        total++; if (!done) begin bad++; $display("FAIL fill_drain_timeout got=busy exp=idle"); end
        total++; if (log_q.size() != 5) begin bad++; $display("FAIL fill_count got=%0d exp=5", log_q.size()); end
        for (int i = 0; i < 5 && i < log_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (log_q[i].is_wr !== 1'b1 || log_q[i].addr !== exp_q[i].addr ||
                log_q[i].data !== exp_q[i].data || log_q[i].be !== exp_q[i].be) begin
                bad++; $display("FAIL fill_order[%0d] got=%h/%h/%h exp=%h/%h/%h", i, log_q[i].addr,
                                log_q[i].data, log_q[i].be, exp_q[i].addr, exp_q[i].data, exp_q[i].be);
            end
        end
    endtask

    // A read behind a queued write must wait for the drain and return the written data.
    task automatic test_ordering();
        bit          ok;
        logic [31:0] d;
        log_q.delete(); exp_q.delete();
        mem_waitrequest = 1'b1;
        do_write(32'h100, 32'hDEADBEEF, 4'hF, ok);
        total++; if (!ok) begin bad++; $display("FAIL order_write_timeout got=stalled exp=accepted"); end
        @(negedge clk);
        cpu_address = 32'h100; cpu_byteenable = 4'hF; cpu_read = 1'b1;
        #1;
        total++; if (cpu_waitrequest !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
            bad++; $display("FAIL order_stall got=%b%b%b exp=110", cpu_waitrequest, mem_write, mem_read);
        end
        mem_waitrequest = 1'b0;
        ok = 1'b0; d = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (!cpu_waitrequest) begin ok = 1'b1; d = cpu_readdata; break; end
        end
        @(negedge clk);
        cpu_read = 1'b0;
        total++; if (!ok || d !== 32'hDEADBEEF) begin bad++; $display("FAIL order_readdata got=%h exp=deadbeef", d); end
        total++;
        if (log_q.size() != 2) begin
            bad++; $display("FAIL order_log_size got=%0d exp=2", log_q.size());
        end else if (!log_q[0].is_wr || log_q[0].addr !== 32'h100 || log_q[1].is_wr || log_q[1].addr !== 32'h100) begin
            bad++; $display("FAIL order_sequence got=%0d@%h,%0d@%h exp=1@100,0@100",
                            log_q[0].is_wr, log_q[0].addr, log_q[1].is_wr, log_q[1].addr);
        end
    endtask

    // Empty FIFO, no memory wait: completion two cycles after the request, for one cycle.
    task automatic test_read_latency();
        bit          ok;
        logic [31:0] d;
        int          lat;
        mem_model[32'h300] = 32'h12345678;
        mem_waitrequest = 1'b0;
        do_read(32'h300, 4'hF, ok, d, lat);
        #1;
        total++; if (!ok || lat != 2) begin bad++; $display("FAIL latency got=%0d exp=2", lat); end
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL latency_data got=%h exp=12345678", d); end
        total++; if (idle !== 1'b1 || cpu_waitrequest !== 1'b0) begin
            bad++; $display("FAIL latency_one_cycle idle/waitreq got=%b/%b exp=1/0", idle, cpu_waitrequest);
        end
        total++; if (cpu_readdata !== 32'h12345678) begin bad++; $display("FAIL readdata_hold got=%h exp=12345678", cpu_readdata); end
    endtask

    // Memory stalls the read for five cycles; request must stay stable throughout.
    task automatic test_mem_stall();
        logic [31:0] val;
        int          held, cyc, unstable;
        bit          ok;
        logic [31:0] d;
        val = $urandom;
        mem_model[32'h400] = val;
        mem_waitrequest = 1'b1;
        held = 0; unstable = 0; ok = 1'b0; d = '0; cyc = 0;
        @(negedge clk);
        cpu_address = 32'h400; cpu_byteenable = 4'h3; cpu_read = 1'b1;
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            cyc = i;
            if (i == 6) mem_waitrequest = 1'b0;
            #1;
            if (mem_read) begin
                held++;
                if (mem_address !== 32'h400 || mem_byteenable !== 4'h3 || mem_write !== 1'b0) unstable++;
            end
            if (!cpu_waitrequest) begin ok = 1'b1; d = cpu_readdata; break; end
        end
        @(negedge clk);
        cpu_read = 1'b0;
        total++; if (held != 6) begin bad++; $display("FAIL stall_hold got=%0d exp=6", held); end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
        total++; if (!ok || cyc != 7) begin bad++; $display("FAIL stall_latency got=%0d exp=7", cyc); end
        total++; if (d !== val) begin bad++; $display("FAIL stall_data got=%h exp=%h", d, val); end
    endtask

    // Twenty random writes against a randomly stalling memory, tracked with an occupancy model.
    task automatic test_random_writes();
        int  model_cnt, sent;
        bit  accepted, pushing, popping, done;
        op_t cur;
        log_q.delete(); exp_q.delete();
        model_cnt = 0; sent = 0; accepted = 1'b0; done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (accepted) cpu_write = 1'b0;
            mem_waitrequest = 1'($urandom_range(0, 1));
            if (!cpu_write && sent < 20 && $urandom_range(0, 3) != 0) begin
                cur = '{is_wr: 1'b1, addr: $urandom, data: $urandom, be: 4'($urandom_range(0, 15))};
                cpu_address = cur.addr; cpu_writedata = cur.data; cpu_byteenable = cur.be; cpu_write = 1'b1;
            end
            #1;
            total++;
            if (mem_write !== (model_cnt != 0)) begin
                bad++; $display("FAIL rand_mem_write cyc=%0d got=%b exp=%b", c, mem_write, (model_cnt != 0));
            end
            if (cpu_write) begin
                total++;
                if (cpu_waitrequest !== (model_cnt == DEPTH)) begin
                    bad++; $display("FAIL rand_waitreq cyc=%0d got=%b exp=%b", c, cpu_waitrequest, (model_cnt == DEPTH));
                end
            end
            pushing  = cpu_write && (model_cnt != DEPTH);
            popping  = (model_cnt != 0) && !mem_waitrequest;
            accepted = pushing;
            if (pushing) begin exp_q.push_back(cur); sent++; end
            model_cnt = model_cnt + int'(pushing) - int'(popping);
            if (sent == 20 && model_cnt == 0 && !pushing) begin done = 1'b1; break; end
        end
        @(negedge clk);
        cpu_write = 1'b0;
        mem_waitrequest = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL rand_timeout got=%0d exp=20", sent); end
        total++; if (log_q.size() != 20) begin bad++; $display("FAIL rand_count got=%0d exp=20", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (log_q[i].is_wr !== 1'b1 || log_q[i].addr !== exp_q[i].addr ||
                log_q[i].data !== exp_q[i].data || log_q[i].be !== exp_q[i].be) begin
                bad++; $display("FAIL rand_order[%0d] got=%h/%h/%h exp=%h/%h/%h", i, log_q[i].addr,
                                log_q[i].data, log_q[i].be, exp_q[i].addr, exp_q[i].data, exp_q[i].be);
            end
        end
    endtask

    // Reset while three writes are still queued: they must vanish.
    task automatic test_reset_mid_drain();
        bit ok;
        int oks;
        oks = 0;
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_write(32'h500 + 32'(4 * i), $urandom, 4'hF, ok);
            oks += int'(ok);
        end
        #1;
        total++; if (oks != 3 || mem_write !== 1'b1) begin
            bad++; $display("FAIL mid_drain_setup got=%0d/%b exp=3/1", oks, mem_write);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL mid_reset_mem_write got=%b exp=0", mem_write); end
        total++; if (idle !== 1'b1)      begin bad++; $display("FAIL mid_reset_idle got=%b exp=1", idle); end
        @(negedge clk);
        reset = 1'b0;
        log_q.delete(); exp_q.delete();
        mem_waitrequest = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        total++; if (log_q.size() != 0) begin bad++; $display("FAIL mid_reset_stale got=%0d exp=0", log_q.size()); end
        total++; if (idle !== 1'b1)      begin bad++; $display("FAIL mid_reset_after_idle got=%b exp=1", idle); end
    endtask

    initial begin
        reset = 1'b1;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_writedata = '0; cpu_byteenable = '0; mem_waitrequest = 1'b0;
        test_reset();
        test_fill_full();
        test_ordering();
        test_read_latency();
        test_mem_stall();
        test_random_writes();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
